// File: rtl/bcd_pkg.sv
// Shared BCD digit type, constants and digit validity helper.
// Used by the counter top and its per-digit step logic.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    function automatic logic is_bcd_digit(input bcd_digit_t d);
        return (d <= BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// Purpose: one BCD digit of an increment/decrement carry/borrow chain.
// Latency: purely combinational.
// Backpressure: none; the digit passes through unchanged when cin is low.
module bcd_digit_step
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    input  logic       cin,
    input  logic       up,
    output bcd_digit_t next_digit,
    output logic       cout
);

    always_comb begin
        next_digit = digit;
        cout       = 1'b0;
        if (cin) begin
            if (up) begin
                if (digit >= BCD_MAX_DIGIT) begin
                    next_digit = '0;
                    cout       = 1'b1;
                end else begin
                    next_digit = digit + bcd_digit_t'(1);
                end
            end else begin
                if (digit == '0) begin
                    next_digit = BCD_MAX_DIGIT;
                    cout       = 1'b1;
                end else begin
                    next_digit = digit - bcd_digit_t'(1);
                end
            end
        end
    end

endmodule

// File: rtl/bcd_counter_4digits.sv
// Purpose: DIGITS-wide BCD up/down counter with validated parallel load (BCD_SATURATE_EN: clamp at limits).
// Latency: one cycle from sampled load/en/up to count, tc and load_err; all outputs registered.
// Backpressure: none; load > en > hold every cycle, bad loads rejected with a load_err pulse.
module bcd_counter_4digits
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      up,
    input  logic                      load,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] load_val,
    output logic [BCD_DIGIT_W*DIGITS-1:0] count,
    output logic                      tc,
    output logic                      load_err
);

    localparam int W = BCD_DIGIT_W * DIGITS;

    logic [W-1:0]    step_val;
    logic [DIGITS:0] carry;
    logic            load_ok;
    logic [W-1:0]    count_nxt;
    logic            tc_nxt;
    logic            load_err_nxt;

    // The chain input is tied high; en decides whether the stepped value is used.
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_step u_step (
            .digit      (count[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .cin        (carry[i]),
            .up         (up),
            .next_digit (step_val[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .cout       (carry[i+1])
        );
    end

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd_digit(load_val[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
                load_ok = 1'b0;
            end
        end
    end

    // A carry out of the top digit means the count is at its limit in the current direction.
    always_comb begin
        count_nxt    = count;
        tc_nxt       = 1'b0;
        load_err_nxt = 1'b0;
        if (load) begin
            if (load_ok) begin
                count_nxt = load_val;
            end else begin
                load_err_nxt = 1'b1;
            end
        end else if (en) begin
            if (carry[DIGITS]) begin
                tc_nxt = 1'b1;
`ifdef BCD_SATURATE_EN
                count_nxt = count;
`else
                count_nxt = step_val;
`endif
            end else begin
                count_nxt = step_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            tc       <= 1'b0;
            load_err <= 1'b0;
        end else begin
            count    <= count_nxt;
            tc       <= tc_nxt;
            load_err <= load_err_nxt;
        end
    end

endmodule
